upsample_2x2: RTL and testbench
===============================

UPSAMPLE_2X2 -- requirements
Module: upsample_2x2

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 12, meaning input feature-map columns (output width 2*IN_WIDTH).
REQ-002 SHALL have parameter IN_HEIGHT, default 12, meaning input feature-map rows (output height 2*IN_HEIGHT).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 valid_in  input  1  input pixel valid.
REQ-006 ready_in  output  1  block accepts input pixel this cycle (combinational).
REQ-007 in_ch0..in_ch5  input  32 each, signed  input pixel, 6 channels, raster order.
REQ-008 out_ch0..out_ch5  output  32 each, signed, registered  output pixel, 6 channels.
REQ-009 out_valid  output  1, registered  output pixel valid.
REQ-010 out_ready  input  1  downstream accepts output pixel.
REQ-011 out_last  output  1, registered  high with the final output pixel of a frame (row 2*IN_HEIGHT-1, col 2*IN_WIDTH-1).

Function
REQ-012 SHALL perform 2x nearest-neighbour upsampling: output(r,c) = input(r/2, c/2), integer division, all channels unmodified, no arithmetic.
REQ-013 Input transfer SHALL occur only when valid_in && ready_in; output transfer only when out_valid && out_ready.
REQ-014 SHALL hold out_ch*, out_valid, out_last stable while out_valid && !out_ready.
REQ-015 SHALL contain a line buffer of IN_WIDTH entries x 6 channels, written at input column index on each input transfer.
REQ-016 FSM states: FILL (accepting input row, emitting even output row), REPLAY (emitting odd output row from line buffer, no input accepted).
REQ-017 FILL: ready_in = !out_valid || (out_ready && phase==1); phase is the horizontal copy index (0 = col 2c, 1 = col 2c+1).
REQ-018 FILL: on input transfer, register pixel to out_ch* with phase=0, out_valid=1 next cycle; on phase-0 output transfer, present same pixel with phase=1 next cycle.
REQ-019 Throughput: one input per 2 cycles, one output per cycle, when valid_in and out_ready held high; latency input transfer -> first out_valid = 1 cycle.
REQ-020 FILL -> REPLAY on output transfer of phase 1 of input column IN_WIDTH-1; ready_in SHALL be 0 throughout REPLAY.
REQ-021 REPLAY: emit linebuf[0..IN_WIDTH-1], each twice (phase 0 then 1), next entry loaded on phase-1 output transfer, no bubbles when out_ready high.
REQ-022 REPLAY -> FILL on output transfer of phase 1 of column IN_WIDTH-1; input row counter increments, wraps to 0 after IN_HEIGHT-1.
REQ-023 out_last SHALL be 1 only for REPLAY, input row IN_HEIGHT-1, column IN_WIDTH-1, phase 1; deasserts after its transfer.
REQ-024 out_valid SHALL drop to 0 after an output transfer in FILL when no input transfer occurs that cycle (phase 1 only).
REQ-025 Column/row counters SHALL be at least 6 bits; valid_in while ready_in=0 SHALL be ignored, no state change.
REQ-026 Frames SHALL be back-to-back: after out_last transfer, next input accepted in same cycle (FILL, ready_in=1).

Reset
REQ-027 On rst_n=0, asynchronously: state=FILL, phase=0, all counters=0, out_valid=0, out_last=0, out_ch0..5=0.
REQ-028 Line buffer contents need not be reset; never read before being written in the current frame.
REQ-029 Reset mid-frame SHALL abandon the frame; after release ready_in=1 and next input is treated as pixel (0,0).

Verification
REQ-030 Single frame, in_chk = 1000*r + 10*c + k, valid_in/out_ready always 1 -> 576 outputs, out(r,c) chk = 1000*(r/2)+10*(c/2)+k, out_last only on output 576.
REQ-031 Throughput: same stimulus -> ready_in pattern 1,0 during FILL, ready_in=0 for 24 cycles in REPLAY, out_valid continuous after first output.
REQ-032 Backpressure: out_ready random 50% -> identical output sequence to REQ-030, outputs stable while stalled, no input lost or duplicated.
REQ-033 Negative data: in_ch0 = -5 (0xFFFFFFFB) at (0,0) -> out_ch0 = -5 at outputs (0,0),(0,1),(1,0),(1,1).
REQ-034 Reset asserted after 30 input transfers -> out_valid=0, outputs 0 immediately; new frame after release matches REQ-030.
REQ-035 Two back-to-back frames -> exactly two out_last pulses, 1152 outputs, second frame starts at input (0,0).

Source files
------------

// File: rtl/upsample_2x2_if.sv
// Streaming handshake bundle for the 2x2 nearest-neighbour upsampler:
// six 32-bit signed channels in and out, valid/ready on each side.
interface upsample_2x2_if;
    logic               valid_in;
    logic               ready_in;
    logic signed [31:0] in_ch0;
    logic signed [31:0] in_ch1;
    logic signed [31:0] in_ch2;
    logic signed [31:0] in_ch3;
    logic signed [31:0] in_ch4;
    logic signed [31:0] in_ch5;
    logic signed [31:0] out_ch0;
    logic signed [31:0] out_ch1;
    logic signed [31:0] out_ch2;
    logic signed [31:0] out_ch3;
    logic signed [31:0] out_ch4;
    logic signed [31:0] out_ch5;
    logic               out_valid;
    logic               out_ready;
    logic               out_last;

    modport slave (
        input  valid_in, in_ch0, in_ch1, in_ch2, in_ch3, in_ch4, in_ch5, out_ready,
        output ready_in, out_ch0, out_ch1, out_ch2, out_ch3, out_ch4, out_ch5,
               out_valid, out_last
    );

    modport master (
        output valid_in, in_ch0, in_ch1, in_ch2, in_ch3, in_ch4, in_ch5, out_ready,
        input  ready_in, out_ch0, out_ch1, out_ch2, out_ch3, out_ch4, out_ch5,
               out_valid, out_last
    );
endinterface

// File: rtl/upsample_2x2.sv
// 2x nearest-neighbour upsampler: even output rows are produced straight from
// the input stream, odd output rows are replayed from a one-row line buffer.
module upsample_2x2 #(
    parameter int IN_WIDTH  = 12,
    parameter int IN_HEIGHT = 12
) (
    input  logic           clk,
    input  logic           rst_n,
    upsample_2x2_if.slave  bus
);
    localparam int DW = 6 * 32;
    localparam int CW = ($clog2(IN_WIDTH + 1) > 6) ? $clog2(IN_WIDTH + 1) : 6;
    localparam int RW = ($clog2(IN_HEIGHT + 1) > 6) ? $clog2(IN_HEIGHT + 1) : 6;
    localparam int AW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IN_HEIGHT - 1);

    typedef enum logic {FILL = 1'b0, REPLAY = 1'b1} state_t;

    state_t          state_reg, state_next;
    logic            phase_reg, phase_next;
    logic [CW-1:0]   in_col_reg, in_col_next;
    logic [CW-1:0]   out_col_reg, out_col_next;
    logic [RW-1:0]   row_reg, row_next;
    logic            out_valid_reg, out_valid_next;
    logic            out_last_reg, out_last_next;
    logic [DW-1:0]   out_data_reg, out_data_next;

    logic [DW-1:0]   linebuf [IN_WIDTH];
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   rd_data;
    logic [AW-1:0]   rd_addr;
    logic            col_last;
    logic            row_last;
    logic            ready;
    logic            in_fire;
    logic            out_fire;

    assign in_data = {bus.in_ch5, bus.in_ch4, bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0};

    assign bus.out_ch0   = out_data_reg[0*32 +: 32];
    assign bus.out_ch1   = out_data_reg[1*32 +: 32];
    assign bus.out_ch2   = out_data_reg[2*32 +: 32];
    assign bus.out_ch3   = out_data_reg[3*32 +: 32];
    assign bus.out_ch4   = out_data_reg[4*32 +: 32];
    assign bus.out_ch5   = out_data_reg[5*32 +: 32];
    assign bus.out_valid = out_valid_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.ready_in  = ready;

    assign col_last = (out_col_reg == COL_LAST);
    assign row_last = (row_reg == ROW_LAST);

    // The last column's phase-1 beat hands over to the replay row, so it must
    // not take a new input even though its output slot is draining.
    assign ready    = (state_reg == FILL) &&
                      (!out_valid_reg || (bus.out_ready && phase_reg && !col_last));
    assign in_fire  = bus.valid_in && ready;
    assign out_fire = out_valid_reg && bus.out_ready;

    // FILL only ever reads entry 0 (entry into REPLAY); REPLAY prefetches the next column.
    assign rd_addr = (state_reg == REPLAY && !col_last) ? AW'(out_col_reg + 1'b1) : '0;
    assign rd_data = linebuf[rd_addr];

    always_ff @(posedge clk) begin
        if (in_fire) begin
            linebuf[in_col_reg[AW-1:0]] <= in_data;
        end
    end

    always_comb begin
        state_next     = state_reg;
        phase_next     = phase_reg;
        in_col_next    = in_col_reg;
        out_col_next   = out_col_reg;
        row_next       = row_reg;
        out_valid_next = out_valid_reg;
        out_last_next  = out_last_reg;
        out_data_next  = out_data_reg;

        case (state_reg)
            FILL: begin
                if (in_fire) begin
                    out_data_next  = in_data;
                    out_valid_next = 1'b1;
                    phase_next     = 1'b0;
                    out_col_next   = in_col_reg;
                    in_col_next    = (in_col_reg == COL_LAST) ? '0 : CW'(in_col_reg + 1'b1);
                end else if (out_fire) begin
                    if (!phase_reg) begin
                        phase_next = 1'b1;
                    end else if (col_last) begin
                        state_next     = REPLAY;
                        phase_next     = 1'b0;
                        out_col_next   = '0;
                        out_data_next  = rd_data;
                        out_valid_next = 1'b1;
                    end else begin
                        out_valid_next = 1'b0;
                    end
                end
            end
            REPLAY: begin
                if (out_fire) begin
                    if (!phase_reg) begin
                        phase_next    = 1'b1;
                        out_last_next = col_last && row_last;
                    end else if (col_last) begin
                        state_next     = FILL;
                        phase_next     = 1'b0;
                        out_col_next   = '0;
                        out_valid_next = 1'b0;
                        out_last_next  = 1'b0;
                        row_next       = row_last ? '0 : RW'(row_reg + 1'b1);
                    end else begin
                        phase_next    = 1'b0;
                        out_col_next  = CW'(out_col_reg + 1'b1);
                        out_data_next = rd_data;
                    end
                end
            end
            default: begin
                state_next = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= FILL;
            phase_reg     <= 1'b0;
            in_col_reg    <= '0;
            out_col_reg   <= '0;
            row_reg       <= '0;
            out_valid_reg <= 1'b0;
            out_last_reg  <= 1'b0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            phase_reg     <= phase_next;
            in_col_reg    <= in_col_next;
            out_col_reg   <= out_col_next;
            row_reg       <= row_next;
            out_valid_reg <= out_valid_next;
            out_last_reg  <= out_last_next;
            out_data_reg  <= out_data_next;
        end
    end
endmodule

// File: tb/tb_upsample_2x2.sv
// Directed bench for upsample_2x2: nominal, back-to-back, backpressure,
// negative data and mid-frame reset, checked with immediate assertions.
module tb_upsample_2x2;
    localparam int W    = 12;
    localparam int H    = 12;
    localparam int OW   = 2 * W;
    localparam int NIN  = W * H;
    localparam int NOUT = 4 * NIN;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    upsample_2x2_if bus ();

    upsample_2x2 #(.IN_WIDTH(W), .IN_HEIGHT(H)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int in_idx = 0;
    int in_limit = 0;
    int out_idx = 0;
    int last_cnt = 0;
    int t = 0;
    bit neg_mode = 1'b0;
    bit tp_mode = 1'b0;
    bit stalled = 1'b0;
    logic [191:0] held_data;
    logic         held_last;

    function automatic logic [191:0] in_pix(input int p);
        logic [191:0] v;
        int q, r, c;
        q = p % NIN;
        r = q / W;
        c = q % W;
        for (int k = 0; k < 6; k++) v[k*32 +: 32] = 32'(1000 * r + 10 * c + k);
        if (neg_mode && q == 0) v[31:0] = 32'hFFFF_FFFB;
        return v;
    endfunction

    function automatic logic [191:0] exp_pix(input int n);
        logic [191:0] v;
        int q, r, c;
        q = n % NOUT;
        r = q / OW;
        c = q % OW;
        for (int k = 0; k < 6; k++) v[k*32 +: 32] = 32'(1000 * (r / 2) + 10 * (c / 2) + k);
        if (neg_mode && r < 2 && c < 2) v[31:0] = 32'hFFFF_FFFB;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cycle(input bit rdy);
        logic [191:0] got;
        @(negedge clk);
        if (in_idx < in_limit) begin
            bus.valid_in = 1'b1;
            {bus.in_ch5, bus.in_ch4, bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0} = in_pix(in_idx);
        end else begin
            bus.valid_in = 1'b0;
        end
        bus.out_ready = rdy;
        #1;
        got = {bus.out_ch5, bus.out_ch4, bus.out_ch3, bus.out_ch2, bus.out_ch1, bus.out_ch0};
        if (stalled) begin
            chk("hold_data", got, held_data);
            chk("hold_valid_last", {bus.out_valid, bus.out_last}, {1'b1, held_last});
        end
        if (tp_mode) begin
            // Row pair period is 49 cycles: 24 FILL outputs, 24 REPLAY outputs, one refill bubble.
            chk("tp_ready", bus.ready_in, ((t % 49) <= 22) && ((t % 49) % 2 == 0));
            chk("tp_valid", bus.out_valid, (t % 49) != 0);
        end
        if (bus.out_valid && bus.out_ready) begin
            chk("data", got, exp_pix(out_idx));
            chk("last", bus.out_last, (out_idx % NOUT) == NOUT - 1);
            if (bus.out_last) last_cnt++;
            out_idx++;
        end
        stalled   = bus.out_valid && !bus.out_ready;
        held_data = got;
        held_last = bus.out_last;
        if (bus.valid_in && bus.ready_in) in_idx++;
        t++;
    endtask

    task automatic run_until(input int target, input bit rnd, input int budget);
        int n = 0;
        while (out_idx < target && n < budget) begin
            cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
            n++;
        end
        chk("outputs_done", out_idx, target);
    endtask

    initial begin
        bus.valid_in  = 1'b0;
        bus.out_ready = 1'b0;
        {bus.in_ch5, bus.in_ch4, bus.in_ch3, bus.in_ch2, bus.in_ch1, bus.in_ch0} = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("reset_ctrl", {bus.out_valid, bus.out_last, bus.ready_in}, 3'b001);
        chk("reset_data", {bus.out_ch5, bus.out_ch4, bus.out_ch3, bus.out_ch2, bus.out_ch1, bus.out_ch0}, '0);

        // Two back-to-back frames, no backpressure, with cycle-exact timing checks.
        in_limit = 2 * NIN;
        t = 0;
        tp_mode = 1'b1;
        run_until(2 * NOUT, 1'b0, 3000);
        tp_mode = 1'b0;
        chk("last_pulses_2", last_cnt, 2);
        chk("inputs_2", in_idx, 2 * NIN);

        // Third frame under random backpressure with a negative pixel at (0,0).
        neg_mode = 1'b1;
        in_limit = 3 * NIN;
        run_until(3 * NOUT, 1'b1, 8000);
        neg_mode = 1'b0;
        chk("last_pulses_3", last_cnt, 3);
        chk("inputs_3", in_idx, 3 * NIN);

        // Abandon a frame after 30 input transfers.
        in_limit = in_idx + 30;
        for (int n = 0; n < 200 && in_idx < in_limit; n++) cycle(1'b1);
        chk("inputs_before_reset", in_idx, in_limit);
        rst_n = 1'b0;
        #1;
        chk("async_reset_ctrl", {bus.out_valid, bus.out_last, bus.ready_in}, 3'b001);
        chk("async_reset_data", {bus.out_ch5, bus.out_ch4, bus.out_ch3, bus.out_ch2, bus.out_ch1, bus.out_ch0}, '0);
        bus.valid_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        in_idx = 0;
        out_idx = 0;
        in_limit = NIN;
        stalled = 1'b0;
        last_cnt = 0;
        run_until(NOUT, 1'b0, 2000);
        chk("last_after_reset", last_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
